rand_lfsr_stream: RTL and testbench



---
 rtl/rand_lfsr_stream.sv | 162 ++++++++++++++++
 tb/tb_rand_lfsr_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_lfsr_stream.sv
// Parametrised Fibonacci LFSR word generator with valid/ready delivery and free-run/burst modes.
// Optional full-period wrap detector enabled by defining RAND_WRAP_DET_EN.
module rand_lfsr_stream #(
  parameter int unsigned       LFSR_W   = 16,
  parameter int unsigned       OUT_W    = 8,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_RST = 16'h00FF,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              set_seed_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  burst_len_i,
  input  logic              stop_i,
  output logic [OUT_W-1:0]  rand_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef RAND_WRAP_DET_EN
  ,
  output logic              wrap_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FREE  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } fsm_e;

  fsm_e              fsm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] adv;
  logic [LFSR_W-1:0] seed_ld;
  logic              accept;

  // OUT_W single shift steps unrolled into one word advance
  function automatic logic [LFSR_W-1:0] word_adv(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    t = s;
    for (int i = 0; i < int'(OUT_W); i++) begin
      t = {t[LFSR_W-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  assign accept  = valid_o && ready_i;
  assign adv     = word_adv(lfsr_q);
  assign seed_ld = (seed_i == '0) ? SEED_RST : seed_i;
  assign rand_o  = lfsr_q[OUT_W-1:0];

  // Seed load beats lockup recovery, which beats the normal advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (set_seed_i) begin
      lfsr_d = seed_ld;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED_RST;
    end else if (accept) begin
      lfsr_d = adv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_RST;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Mode control with registered stream/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (!mode_i) begin
              fsm_q   <= S_FREE;
              valid_o <= 1'b1;
            end else begin
              cnt_q <= burst_len_i;
              if (burst_len_i != '0) begin
                fsm_q   <= S_BURST;
                valid_o <= 1'b1;
              end else begin
                fsm_q  <= S_DONE;
                done_o <= 1'b1;
              end
            end
          end
        end
        S_FREE: begin
          if (stop_i) begin
            fsm_q   <= S_IDLE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        S_BURST: begin
          // An abort wins over a completing accept, so no done pulse
          if (stop_i) begin
            fsm_q   <= S_IDLE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
          end else if (accept) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              fsm_q   <= S_DONE;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          fsm_q  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          fsm_q   <= S_IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAND_WRAP_DET_EN
  logic [LFSR_W-1:0] seed_q;

  // A wrap is an advance landing back on the last loaded seed; a same-cycle reload suppresses it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= SEED_RST;
      wrap_o <= 1'b0;
    end else begin
      wrap_o <= accept && !set_seed_i && (adv == seed_q);
      if (set_seed_i) begin
        seed_q <= seed_ld;
      end else if (lfsr_q == '0) begin
        seed_q <= SEED_RST;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rand_lfsr_stream.sv
// Scoreboard bench for rand_lfsr_stream: a per-cycle behavioural model queues expected outputs,
// a negedge monitor pops and compares; directed scenarios plus a randomized phase.
module tb_rand_lfsr_stream;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [15:0] SEED   = 16'h00FF;

  logic              clk = 1'b0;
  logic              rst;
  logic [LFSR_W-1:0] seed_i;
  logic              set_seed_i;
  logic              start_i;
  logic              mode_i;
  logic [CNT_W-1:0]  burst_len_i;
  logic              stop_i;
  logic [OUT_W-1:0]  rand_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic              done_o;
  logic              wrap_w;

  rand_lfsr_stream dut (
    .clk        (clk),
    .rst        (rst),
    .seed_i     (seed_i),
    .set_seed_i (set_seed_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .burst_len_i(burst_len_i),
    .stop_i     (stop_i),
    .rand_o     (rand_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef RAND_WRAP_DET_EN
    ,
    .wrap_o     (wrap_w)
`endif
  );

`ifndef RAND_WRAP_DET_EN
  assign wrap_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       v;
    logic       b;
    logic       d;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   first_wrap = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word advance as eight parity-of-taps shifts
  function automatic logic [15:0] m_adv(input logic [15:0] s);
    logic [15:0] t;
    logic        f;
    t = s;
    for (int k = 0; k < 8; k++) begin
      f = 1'($countones(t & TAPS) % 2);
      t = 16'((t << 1) | 16'(f));
    end
    return t;
  endfunction

  // Behavioural model: phase 0 idle, 1 free, 2 burst, 3 done
  int          m_phase = 0;
  int          m_left  = 0;
  logic [15:0] m_lfsr  = SEED;
  logic [15:0] m_seed  = SEED;
  logic        m_wrap  = 1'b0;

  always @(posedge clk) begin
    bit acc;
    logic [15:0] nxt;
    exp_t e;
    if (rst) begin
      m_phase = 0; m_left = 0; m_lfsr = SEED; m_seed = SEED; m_wrap = 1'b0;
    end else begin
      acc = (m_phase == 1 || m_phase == 2) && ready_i;
      m_wrap = acc && !set_seed_i && (m_adv(m_lfsr) == m_seed);
      if (set_seed_i) begin
        nxt = (seed_i == 16'h0) ? SEED : seed_i;
        m_seed = nxt;
      end else if (m_lfsr == 16'h0) begin
        nxt = SEED;
        m_seed = SEED;
      end else if (acc) begin
        nxt = m_adv(m_lfsr);
      end else begin
        nxt = m_lfsr;
      end
      m_lfsr = nxt;
      if (m_phase == 3) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (start_i) begin
          if (!mode_i) m_phase = 1;
          else if (burst_len_i == 0) m_phase = 3;
          else begin m_phase = 2; m_left = int'(burst_len_i); end
        end
      end else if (stop_i) begin
        m_phase = 0;
      end else if (m_phase == 2 && acc) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 3;
      end
    end
    e.r = m_lfsr[7:0];
    e.v = (m_phase == 1 || m_phase == 2);
    e.b = (m_phase != 0);
    e.d = (m_phase == 3);
`ifdef RAND_WRAP_DET_EN
    e.w = m_wrap;
`else
    e.w = 1'b0;
`endif
    q.push_back(e);
  end

  // Monitor: one expected entry per cycle, compared away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (rst) begin
        acc_cnt = 0;
      end else begin
        chk("rand_o",  32'(rand_o),  32'(e.r));
        chk("valid_o", 32'(valid_o), 32'(e.v));
        chk("busy_o",  32'(busy_o),  32'(e.b));
        chk("done_o",  32'(done_o),  32'(e.d));
`ifdef RAND_WRAP_DET_EN
        chk("wrap_o",  32'(wrap_w),  32'(e.w));
`endif
        if (wrap_w && first_wrap < 0) first_wrap = acc_cnt;
        if (done_o) done_cnt++;
        if (valid_o && ready_i) acc_cnt++;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    set_seed_i = 1'b0; start_i = 1'b0; mode_i = 1'b0;
    burst_len_i = '0; stop_i = 1'b0; ready_i = 1'b0; seed_i = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    logic [7:0] held;
    rst = 1'b1;
    idle_inputs();
    cyc(2);
    chk("rst_rand", 32'(rand_o), 32'h00FF);
    chk("rst_valid", 32'(valid_o), 32'h0);
    rst = 1'b0;
    cyc(1);

`ifdef RAND_WRAP_DET_EN
    start_i = 1'b1; ready_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    cyc(65540);
    chk("first_wrap_accepts", 32'(first_wrap), 32'd65535);
    stop_i = 1'b1; ready_i = 1'b0;
    cyc(1);
    stop_i = 1'b0;
    cyc(2);
`endif

    // Seed 0001, one accepted word: 01 then 00
    seed_i = 16'h0001; set_seed_i = 1'b1;
    cyc(1);
    set_seed_i = 1'b0; start_i = 1'b1; mode_i = 1'b0;
    cyc(1);
    start_i = 1'b0;
    chk("seed1_valid", 32'(valid_o), 32'h1);
    chk("seed1_word0", 32'(rand_o), 32'h01);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    chk("seed1_word1", 32'(rand_o), 32'h00);
    stop_i = 1'b1;
    cyc(1);
    stop_i = 1'b0;
    chk("stop_free_busy", 32'(busy_o), 32'h0);

    // Zero seed substitution
    seed_i = 16'h0000; set_seed_i = 1'b1;
    cyc(1);
    set_seed_i = 1'b0;
    chk("zero_seed_rand", 32'(rand_o), 32'h00FF);

    // Burst of 3 with toggling ready
    a0 = acc_cnt; d0 = done_cnt;
    start_i = 1'b1; mode_i = 1'b1; burst_len_i = 8'd3;
    cyc(1);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ready_i = (i % 2 == 0);
      held = rand_o;
      cyc(1);
      if (i % 2 == 1) chk("burst_hold", 32'(rand_o), 32'(held));
    end
    ready_i = 1'b0;
    chk("burst_done", 32'(done_o), 32'h1);
    chk("burst_busy_in_done", 32'(busy_o), 32'h1);
    cyc(1);
    chk("burst_done_clear", 32'(done_o), 32'h0);
    chk("burst_busy_fall", 32'(busy_o), 32'h0);
    cyc(1);
    chk("burst_accepts", 32'(acc_cnt - a0), 32'd3);
    chk("burst_done_count", 32'(done_cnt - d0), 32'd1);

    // Zero-length burst
    start_i = 1'b1; mode_i = 1'b1; burst_len_i = 8'd0; ready_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("len0_done", 32'(done_o), 32'h1);
    chk("len0_valid", 32'(valid_o), 32'h0);
    cyc(1);
    chk("len0_busy", 32'(busy_o), 32'h0);
    ready_i = 1'b0;

    // Abort mid-burst
    d0 = done_cnt;
    start_i = 1'b1; mode_i = 1'b1; burst_len_i = 8'd10;
    cyc(1);
    start_i = 1'b0; ready_i = 1'b1;
    cyc(3);
    stop_i = 1'b1;
    cyc(1);
    stop_i = 1'b0; ready_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'h0);
    chk("abort_valid", 32'(valid_o), 32'h0);
    cyc(2);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Asynchronous reset mid-cycle during a burst
    start_i = 1'b1; mode_i = 1'b1; burst_len_i = 8'd20;
    cyc(1);
    start_i = 1'b0; ready_i = 1'b1;
    cyc(3);
    ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rand", 32'(rand_o), 32'h00FF);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_seed_i  = ($urandom_range(0, 31) == 0);
      seed_i      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      start_i     = ($urandom_range(0, 7) == 0);
      mode_i      = 1'($urandom_range(0, 1));
      burst_len_i = 8'($urandom_range(0, 6));
      stop_i      = ($urandom_range(0, 19) == 0);
      ready_i     = 1'($urandom_range(0, 1));
      cyc(1);
    end
    idle_inputs();
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
